sprite_cmd_fifo: RTL and testbench
==================================

# sprite_cmd_fifo

Parametrised sprite command FIFO between the SPI byte receiver and the sprite renderer. Assembles big-endian byte streams into sprite records (id, x, y, scale) and stores them in a circular buffer of configurable depth. Presents the head record through a valid/ready port. Also provides flush, abort of partial records on frame end, and sticky overflow reporting.

## Interface
- DEPTH, 16: record slots; power of two, ≥ 2.
- ID_W, 8: sprite id width; multiple of 8.
- COORD_W, 16: x and y width; multiple of 8.
- SCALE_W, 8: scale width; multiple of 8.
- Derived RECORD_BYTES = (ID_W + 2·COORD_W + SCALE_W)/8, which is 6 at the defaults.

Ports:
- clock  in  1  sole clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high.
- frame_active  in  1  high while SPI chip-select is asserted.
- byte_valid  in  1  one-cycle strobe per received byte.
- byte_data  in  8  received byte.
- flush  in  1  clears queue and assembler.
- out_ready  in  1  consumer accepts head record.
- out_valid  out  1  head record present.
- out_id  out  ID_W  head sprite id.
- out_x  out  COORD_W  head x.
- out_y  out  COORD_W  head y.
- out_scale  out  SCALE_W  head scale.
- count  out  $clog2(DEPTH)+1  stored records.
- full  out  1  count == DEPTH.
- overflow  out  1  sticky: a completed record was dropped.
- overflow_clear  in  1  clears overflow.

## Operation
- **Byte assembler:** byte index `bidx` runs 0..RECORD_BYTES-1.
  - Field order is id, x, y, scale, each MSB byte first.
  - A byte is accepted only when byte_valid && frame_active.
  - An accepted byte shifts into the staging register and increments bidx.
- **Commit:** happens on an accepted byte with bidx == RECORD_BYTES-1.
  - The record is written at wr_ptr, wr_ptr advances (mod DEPTH, natural wrap), and bidx returns to 0.
  - If the FIFO is full and no pop occurs that cycle, the record is discarded, overflow is set, and bidx returns to 0.
- **Frame abort:** frame_active low forces bidx to 0 and discards the partial record, with no flag. byte_valid while frame_active is low is ignored.
- **Pop:** occurs when out_valid && out_ready; rd_ptr advances (mod DEPTH).
- **Head outputs:**
  - out_valid = (count != 0).
  - out_* show mem[rd_ptr] when out_valid, and are all-zero otherwise.
- **Count update:**
  - Commit with pop: count unchanged. A commit is accepted when full if a pop occurs in the same cycle.
  - Commit alone: count + 1.
  - Pop alone: count − 1.
  - Pop when empty is impossible, since out_valid is low.
- **flush:** highest priority after reset.
  - Sets rd_ptr = wr_ptr = 0, count = 0, bidx = 0.
  - Any commit or pop in the same cycle is suppressed.
  - overflow is unchanged.
- **overflow:**
  - Set has priority over overflow_clear in the same cycle.
  - Cleared only by overflow_clear or reset.
- Storage array is not reset; the pointers and count are.

## Timing
- **Reset:** count = 0, rd_ptr = wr_ptr = 0, bidx = 0, overflow = 0, out_valid = 0, full = 0, out_* = 0.
  - Reset during a partial record discards it.
- **Write latency:** commit on the edge of the last byte; out_valid (if previously empty) and count reflect it the following cycle. One cycle from last byte to visible.
- **Read latency:**
  - A pop on edge N presents the next head (or out_valid = 0) after edge N.
  - out_* are combinational from registered state, with no extra read latency.
- **Throughput:** back-to-back bytes every cycle supported; consecutive pops every cycle supported.
- **Wrap:** pointers wrap DEPTH-1 → 0 without gaps; full and empty are distinguished by count only.
- **flush mid-record:** the next accepted byte is treated as the id byte.

## Test plan
- Basic record (defaults; bench uses DEPTH=4):
  - Stimulus: frame_active=1, bytes 01 00 C8 01 2C 02 on consecutive cycles.
  - Response: out_valid=1 one cycle after the last byte, with out_id=01, out_x=200, out_y=300, out_scale=2 and count=1.
  - Then pulse out_ready: out_valid=0 and count=0 next cycle.
- Fill and overflow:
  - Stimulus: 5 records with ids 1..5, out_ready=0.
  - Response: full=1 after the 4th; the 5th is dropped and overflow=1.
  - Then pop 4 times: ids 1,2,3,4 in order.
  - Then overflow_clear: overflow=0.
- Simultaneous commit and pop when full:
  - Stimulus: 4 records stored, out_ready=1 on the cycle the 5th record's last byte arrives.
  - Response: count stays 4, overflow stays 0, and the subsequent drain yields ids 2,3,4,5.
- Frame abort:
  - Stimulus: 3 bytes, frame_active low for 1 cycle, then a full 6-byte record with id 07.
  - Response: exactly one record stored, with out_id=07.
- Wrap-around:
  - Stimulus: 10 records with ids 1..10, interleaved push/pop keeping count ≤ 2.
  - Response: ids pop in order 1..10 with no loss or duplication.
- Flush and reset:
  - Stimulus: 2 records plus 2 partial bytes, then flush.
  - Response: count=0 and out_valid=0 next cycle; overflow is preserved. A following record's first byte is taken as the id.
  - Repeat with reset: all outputs are zero.

Source files
------------

// File: rtl/sprite_cmd_fifo.sv
// Sprite command FIFO: packs big-endian SPI bytes into (id, x, y, scale) records
// and queues them in a circular buffer, presented through a valid/ready head port.
module sprite_cmd_fifo #(
    parameter int DEPTH   = 16,
    parameter int ID_W    = 8,
    parameter int COORD_W = 16,
    parameter int SCALE_W = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       frame_active,
    input  logic                       byte_valid,
    input  logic [7:0]                 byte_data,
    input  logic                       flush,
    input  logic                       out_ready,
    output logic                       out_valid,
    output logic [ID_W-1:0]            out_id,
    output logic [COORD_W-1:0]         out_x,
    output logic [COORD_W-1:0]         out_y,
    output logic [SCALE_W-1:0]         out_scale,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       overflow,
    input  logic                       overflow_clear
);

    localparam int RECORD_BYTES = (ID_W + 2 * COORD_W + SCALE_W) / 8;
    localparam int REC_W        = RECORD_BYTES * 8;
    localparam int PTR_W        = $clog2(DEPTH);
    localparam int CNT_W        = PTR_W + 1;
    localparam int BIDX_W       = $clog2(RECORD_BYTES);
    localparam logic [BIDX_W-1:0] LAST_BIDX = BIDX_W'(RECORD_BYTES - 1);
    localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(DEPTH);

    // Bit offsets of each field inside a stored record (id occupies the MSBs).
    localparam int SCALE_LSB = 0;
    localparam int Y_LSB     = SCALE_W;
    localparam int X_LSB     = SCALE_W + COORD_W;
    localparam int ID_LSB    = SCALE_W + 2 * COORD_W;

    logic [REC_W-1:0]  mem [DEPTH];

    logic [REC_W-9:0]  stage_reg;
    logic [BIDX_W-1:0] bidx_reg;
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;
    logic              overflow_reg;

    logic              accept;
    logic              last_byte;
    logic              pop;
    logic              commit;
    logic              drop;
    logic [REC_W-1:0]  record_next;
    logic [REC_W-1:0]  head_raw;
    logic [REC_W-1:0]  head;

    assign accept      = byte_valid && frame_active;
    assign last_byte   = accept && (bidx_reg == LAST_BIDX);
    assign out_valid   = (count_reg != '0);
    assign full        = (count_reg == DEPTH_CNT);
    assign pop         = out_valid && out_ready && !flush;
    // A full queue can still take a record when the head leaves in the same cycle.
    assign commit      = last_byte && !flush && (!full || pop);
    assign drop        = last_byte && !flush && full && !pop;
    assign record_next = {stage_reg, byte_data};

    // Byte assembler: index and staging shift register.
    always_ff @(posedge clock) begin
        if (reset) begin
            bidx_reg  <= '0;
            stage_reg <= '0;
        end else if (flush || !frame_active) begin
            bidx_reg  <= '0;
        end else if (accept) begin
            stage_reg <= record_next[REC_W-9:0];
            if (last_byte) begin
                bidx_reg <= '0;
            end else begin
                bidx_reg <= bidx_reg + 1'b1;
            end
        end
    end

    // Record storage is deliberately left unreset; only the pointers matter.
    always_ff @(posedge clock) begin
        if (commit && !reset) begin
            mem[wr_ptr_reg] <= record_next;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (commit) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (commit && !pop) begin
                count_reg <= count_reg + 1'b1;
            end else if (pop && !commit) begin
                count_reg <= count_reg - 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            overflow_reg <= 1'b0;
        end else if (drop) begin
            overflow_reg <= 1'b1;
        end else if (overflow_clear) begin
            overflow_reg <= 1'b0;
        end
    end

    assign head_raw = mem[rd_ptr_reg];

    // Head is forced to zero when empty so stale slots never leak out.
    genvar gi;
    generate
        for (gi = 0; gi < REC_W; gi++) begin : g_head_mask
            assign head[gi] = head_raw[gi] & out_valid;
        end
    endgenerate

    assign out_id    = head[ID_LSB    +: ID_W];
    assign out_x     = head[X_LSB     +: COORD_W];
    assign out_y     = head[Y_LSB     +: COORD_W];
    assign out_scale = head[SCALE_LSB +: SCALE_W];
    assign count     = count_reg;
    assign overflow  = overflow_reg;

endmodule

// File: tb/tb_sprite_cmd_fifo.sv
// Scoreboard bench for sprite_cmd_fifo at DEPTH=4: stimulus queues expected
// head records, an independent monitor checks every popped record.
module tb_sprite_cmd_fifo;

    logic        clock = 1'b0;
    logic        reset;
    logic        frame_active;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        flush;
    logic        out_ready;
    logic        out_valid;
    logic [7:0]  out_id;
    logic [15:0] out_x;
    logic [15:0] out_y;
    logic [7:0]  out_scale;
    logic [2:0]  count;
    logic        full;
    logic        overflow;
    logic        overflow_clear;

    int n_cmp = 0;
    int n_err = 0;
    logic [47:0] exp_q[$];

    sprite_cmd_fifo #(.DEPTH(4), .ID_W(8), .COORD_W(16), .SCALE_W(8)) dut (
        .clock(clock), .reset(reset), .frame_active(frame_active),
        .byte_valid(byte_valid), .byte_data(byte_data), .flush(flush),
        .out_ready(out_ready), .out_valid(out_valid), .out_id(out_id),
        .out_x(out_x), .out_y(out_y), .out_scale(out_scale), .count(count),
        .full(full), .overflow(overflow), .overflow_clear(overflow_clear)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // Monitor: every accepted head must match the oldest expected record.
    always @(negedge clock) begin
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pop", {16'h0, out_id, out_x, out_y, out_scale}, 64'hDEAD);
            end else begin
                check("head_record", {16'h0, out_id, out_x, out_y, out_scale},
                      {16'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        byte_valid = 1'b1;
        byte_data  = b;
        tick();
        byte_valid = 1'b0;
    endtask

    task automatic send_rec(input logic [7:0] id, input logic [15:0] x, input logic [15:0] y,
                            input logic [7:0] sc, input bit store, input bit pop_last);
        if (store) exp_q.push_back({id, x, y, sc});
        send_byte(id);
        send_byte(x[15:8]);
        send_byte(x[7:0]);
        send_byte(y[15:8]);
        send_byte(y[7:0]);
        out_ready = pop_last;
        send_byte(sc);
        out_ready = 1'b0;
    endtask

    // Simple numbered record: x = 10_id, y = 20_id, scale = id + 0x30.
    task automatic send_num(input logic [7:0] id, input bit store, input bit pop_last);
        send_rec(id, {8'h10, id}, {8'h20, id}, id + 8'h30, store, pop_last);
    endtask

    task automatic drain();
        int cyc = 0;
        out_ready = 1'b1;
        while (count != 0 && cyc < 50) begin
            tick();
            cyc++;
        end
        out_ready = 1'b0;
        check("drain_done", {61'h0, count}, 64'h0);
        check("scoreboard_empty", exp_q.size(), 64'h0);
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_count"}, {61'h0, count}, 64'h0);
        check({tag, "_valid"}, {63'h0, out_valid}, 64'h0);
        check({tag, "_full"}, {63'h0, full}, 64'h0);
        check({tag, "_overflow"}, {63'h0, overflow}, 64'h0);
        check({tag, "_head"}, {16'h0, out_id, out_x, out_y, out_scale}, 64'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; frame_active = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
        flush = 1'b0; out_ready = 1'b0; overflow_clear = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check_all_zero("reset");

        // Basic record 01 00C8 012C 02
        frame_active = 1'b1;
        send_rec(8'h01, 16'd200, 16'd300, 8'h02, 1'b1, 1'b0);
        check("basic_valid", {63'h0, out_valid}, 64'h1);
        check("basic_count", {61'h0, count}, 64'h1);
        check("basic_id", {56'h0, out_id}, 64'h01);
        check("basic_x", {48'h0, out_x}, 64'd200);
        check("basic_y", {48'h0, out_y}, 64'd300);
        check("basic_scale", {56'h0, out_scale}, 64'h02);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("basic_pop_valid", {63'h0, out_valid}, 64'h0);
        check("basic_pop_count", {61'h0, count}, 64'h0);

        // Fill and overflow
        for (int i = 1; i <= 4; i++) send_num(8'(i), 1'b1, 1'b0);
        check("fill_full", {63'h0, full}, 64'h1);
        check("fill_count", {61'h0, count}, 64'h4);
        check("fill_no_ovf", {63'h0, overflow}, 64'h0);
        send_num(8'h05, 1'b0, 1'b0);
        check("ovf_set", {63'h0, overflow}, 64'h1);
        check("ovf_count", {61'h0, count}, 64'h4);
        drain();
        check("ovf_sticky", {63'h0, overflow}, 64'h1);
        overflow_clear = 1'b1;
        tick();
        overflow_clear = 1'b0;
        check("ovf_cleared", {63'h0, overflow}, 64'h0);

        // Commit and pop in the same cycle while full
        for (int i = 1; i <= 4; i++) send_num(8'(i), 1'b1, 1'b0);
        send_num(8'h05, 1'b1, 1'b1);
        check("simul_count", {61'h0, count}, 64'h4);
        check("simul_no_ovf", {63'h0, overflow}, 64'h0);
        check("simul_head", {56'h0, out_id}, 64'h02);
        drain();

        // Frame abort mid-record
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        frame_active = 1'b0;
        tick();
        frame_active = 1'b1;
        send_num(8'h07, 1'b1, 1'b0);
        check("abort_count", {61'h0, count}, 64'h1);
        check("abort_id", {56'h0, out_id}, 64'h07);
        drain();

        // Wrap-around in pairs: pointers cross slot 3 -> 0 repeatedly
        for (int p = 0; p < 5; p++) begin
            send_num(8'(2 * p + 1), 1'b1, 1'b0);
            send_num(8'(2 * p + 2), 1'b1, 1'b0);
            check("wrap_pair_count", {61'h0, count}, 64'h2);
            drain();
        end

        // Flush: overflow survives, partial bytes are discarded
        for (int i = 1; i <= 5; i++) send_num(8'(i + 8'h40), 1'b0, 1'b0);
        check("flush_pre_ovf", {63'h0, overflow}, 64'h1);
        pulse_flush();
        check("flush1_count", {61'h0, count}, 64'h0);
        send_num(8'h51, 1'b0, 1'b0);
        send_num(8'h52, 1'b0, 1'b0);
        send_byte(8'hEE);
        send_byte(8'hEF);
        pulse_flush();
        check("flush2_count", {61'h0, count}, 64'h0);
        check("flush2_valid", {63'h0, out_valid}, 64'h0);
        check("flush2_ovf", {63'h0, overflow}, 64'h1);
        send_num(8'h09, 1'b1, 1'b0);
        check("flush_next_id", {56'h0, out_id}, 64'h09);
        check("flush_next_count", {61'h0, count}, 64'h1);
        drain();

        // Reset with a stored record and a partial one pending
        send_num(8'h61, 1'b0, 1'b0);
        send_byte(8'h62);
        send_byte(8'h63);
        pulse_reset();
        check_all_zero("reset2");
        send_num(8'h0A, 1'b1, 1'b0);
        check("reset_next_id", {56'h0, out_id}, 64'h0A);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
